// File: rtl/register_block_pkg.sv
// register_block_pkg: shared sizes and lane/warp typedefs for register_block and its port controller
package register_block_pkg;
  localparam int LANES = 16;
  localparam int NREGS = 16;
  localparam int NWARPS = 16;
  localparam int DW = 32;
  typedef logic [$clog2(NWARPS)-1:0] warp_t;
  typedef logic [$clog2(NREGS)-1:0] raddr_t;
  typedef logic [LANES-1:0] lane_mask_t;
  typedef logic [LANES*DW-1:0] lane_data_t;
endpackage

// File: rtl/rbpc_arbiter.sv
// rbpc_arbiter: grants the shared warp selector to a writeback and/or an operand read.
// Ports: wr_pend/rd_pend request flags, wr_warp/rd_warp warps, wr_gnt/rd_gnt grants, starve_cnt read-loss counter.
module rbpc_arbiter #(
  parameter int WSW = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_pend,
  input  logic           rd_pend,
  input  logic [WSW-1:0] wr_warp,
  input  logic [WSW-1:0] rd_warp,
  output logic           wr_gnt,
  output logic           rd_gnt,
  output logic [1:0]     starve_cnt
);
  logic same;
  logic starved;
  always_comb begin
    same = wr_warp == rd_warp;
    starved = starve_cnt == 2'(STARVE_MAX);
    wr_gnt = wr_pend && (!rd_pend || same || !starved);
    rd_gnt = rd_pend && (!wr_pend || same || starved);
  end
  // A read that keeps losing to writes of another warp counts up until it is forced through.
  always_ff @(posedge clk)
    if (rst || rd_gnt || !rd_pend) starve_cnt <= '0;
    else if (wr_gnt) starve_cnt <= starve_cnt + 2'd1;
endmodule

// File: rtl/register_block_port_ctrl.sv
// register_block_port_ctrl: sole initiator of register_block, arbitrating operand reads and writebacks.
// Ports: rd_req_* read requests, wb_* writebacks, rsp_* registered operand response, rf_* register_block drive/readback.
module register_block_port_ctrl
  import register_block_pkg::*;
#(
  parameter int LANES = register_block_pkg::LANES,
  parameter int NREGS = register_block_pkg::NREGS,
  parameter int NWARPS = register_block_pkg::NWARPS,
  parameter int DW = register_block_pkg::DW,
  parameter int STARVE_MAX = 3,
  localparam int RAW = $clog2(NREGS),
  localparam int WSW = $clog2(NWARPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [WSW-1:0]      rd_req_warp,
  input  logic [RAW-1:0]      rd_req_rs0,
  input  logic [RAW-1:0]      rd_req_rs1,
  input  logic [LANES-1:0]    rd_req_mask,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [WSW-1:0]      wb_warp,
  input  logic [RAW-1:0]      wb_rd,
  input  logic [LANES-1:0]    wb_mask,
  input  logic [LANES*DW-1:0] wb_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [LANES*DW-1:0] rsp_op0,
  output logic [LANES*DW-1:0] rsp_op1,
  output logic [LANES-1:0]    rsp_mask,
  output logic [LANES-1:0]    rf_read_en_0,
  output logic [LANES-1:0]    rf_read_en_1,
  output logic [RAW-1:0]      rf_raddr_0,
  output logic [RAW-1:0]      rf_raddr_1,
  output logic [LANES-1:0]    rf_write_en,
  output logic [RAW-1:0]      rf_waddr,
  output logic [LANES*DW-1:0] rf_wdata,
  output logic [WSW-1:0]      rf_warp_selector,
  input  logic [LANES*DW-1:0] rf_rdata_0,
  input  logic [LANES*DW-1:0] rf_rdata_1
);
  logic wr_gnt;
  logic rd_gnt;
  logic [1:0] starve_cnt;
  logic fwd0;
  logic fwd1;
  logic [LANES*DW-1:0] cap0;
  logic [LANES*DW-1:0] cap1;
  // Requests seen while in reset are masked so nothing is accepted then.
  rbpc_arbiter #(.WSW(WSW), .STARVE_MAX(STARVE_MAX)) u_arb (
    .clk(clk),
    .rst(rst),
    .wr_pend(wb_valid && !rst),
    .rd_pend(rd_req_valid && (!rsp_valid || rsp_ready) && !rst),
    .wr_warp(wb_warp),
    .rd_warp(rd_req_warp),
    .wr_gnt(wr_gnt),
    .rd_gnt(rd_gnt),
    .starve_cnt(starve_cnt)
  );
  always_comb begin
    wb_ready = wr_gnt;
    rd_req_ready = rd_gnt;
    rf_warp_selector = wr_gnt ? wb_warp : rd_gnt ? rd_req_warp : '0;
    rf_write_en = wr_gnt ? wb_mask : '0;
    rf_read_en_0 = rd_gnt ? rd_req_mask : '0;
    rf_read_en_1 = rd_gnt ? rd_req_mask : '0;
    rf_raddr_0 = rd_req_rs0;
    rf_raddr_1 = rd_req_rs1;
    rf_waddr = wb_rd;
    rf_wdata = wb_data;
    // Both granted implies the same warp, so the write lands in the register being read this cycle.
    fwd0 = wr_gnt && rd_gnt && wb_rd == rd_req_rs0;
    fwd1 = wr_gnt && rd_gnt && wb_rd == rd_req_rs1;
    cap0 = '0;
    cap1 = '0;
    for (int i = 0; i < LANES; i++) begin
      cap0[i*DW +: DW] = !rd_req_mask[i] ? '0 : (fwd0 && wb_mask[i]) ? wb_data[i*DW +: DW] : rf_rdata_0[i*DW +: DW];
      cap1[i*DW +: DW] = !rd_req_mask[i] ? '0 : (fwd1 && wb_mask[i]) ? wb_data[i*DW +: DW] : rf_rdata_1[i*DW +: DW];
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_op0 <= '0;
      rsp_op1 <= '0;
      rsp_mask <= '0;
    end else if (rd_gnt) begin
      rsp_valid <= 1'b1;
      rsp_op0 <= cap0;
      rsp_op1 <= cap1;
      rsp_mask <= rd_req_mask;
    end else if (rsp_ready) rsp_valid <= 1'b0;
endmodule

// File: tb/tb_register_block_port_ctrl.sv
// tb_register_block_port_ctrl: directed self-checking bench with a behavioural register_block behind the DUT
module tb_register_block_port_ctrl;
  localparam int L = 16;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req_valid = 1'b0, rd_req_ready;
  logic [3:0] rd_req_warp = '0, rd_req_rs0 = '0, rd_req_rs1 = '0;
  logic [L-1:0] rd_req_mask = '0;
  logic wb_valid = 1'b0, wb_ready;
  logic [3:0] wb_warp = '0, wb_rd = '0;
  logic [L-1:0] wb_mask = '0;
  logic [L*DW-1:0] wb_data = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [L*DW-1:0] rsp_op0, rsp_op1;
  logic [L-1:0] rsp_mask, rf_read_en_0, rf_read_en_1, rf_write_en;
  logic [3:0] rf_raddr_0, rf_raddr_1, rf_waddr, rf_warp_selector;
  logic [L*DW-1:0] rf_wdata, rf_rdata_0, rf_rdata_1;
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] mem [16][16][16];
  bit [L-1:0] wmark [16][16];

  always #5 clk = ~clk;

  register_block_port_ctrl dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_warp(rd_req_warp),
    .rd_req_rs0(rd_req_rs0), .rd_req_rs1(rd_req_rs1), .rd_req_mask(rd_req_mask),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp), .wb_rd(wb_rd),
    .wb_mask(wb_mask), .wb_data(wb_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op0(rsp_op0), .rsp_op1(rsp_op1),
    .rsp_mask(rsp_mask), .rf_read_en_0(rf_read_en_0), .rf_read_en_1(rf_read_en_1),
    .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1), .rf_write_en(rf_write_en),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_warp_selector(rf_warp_selector),
    .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1)
  );

  // Unwritten register cells read as 0x10WWRRLL so every location is distinguishable.
  function automatic logic [DW-1:0] pat(input int w, input int r, input int l);
    return 32'h1000_0000 + 32'(w << 16) + 32'(r << 8) + 32'(l);
  endfunction

  always @(posedge clk)
    for (int l = 0; l < L; l++)
      if (rf_write_en[l]) begin
        mem[rf_warp_selector][rf_waddr][l] <= rf_wdata[l*DW +: DW];
        wmark[rf_warp_selector][rf_waddr][l] <= 1'b1;
      end

  always_comb
    for (int l = 0; l < L; l++) begin
      rf_rdata_0[l*DW +: DW] = wmark[rf_warp_selector][rf_raddr_0][l] ? mem[rf_warp_selector][rf_raddr_0][l] : pat(int'(rf_warp_selector), int'(rf_raddr_0), l);
      rf_rdata_1[l*DW +: DW] = wmark[rf_warp_selector][rf_raddr_1][l] ? mem[rf_warp_selector][rf_raddr_1][l] : pat(int'(rf_warp_selector), int'(rf_raddr_1), l);
    end

  function automatic logic [DW-1:0] lane(input logic [L*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rd_req_valid = 1'b1; rd_req_mask = 16'hFFFF;
    wb_valid = 1'b1; wb_mask = 16'hFFFF;
    @(negedge clk); @(negedge clk);
    n_checks++; if (rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ready: got %b expected 0", rd_req_ready); end
    n_checks++; if (rf_write_en !== 16'h0) begin n_fail++; $display("FAIL reset_write_en: got %h expected 0000", rf_write_en); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_op0 !== '0 || rsp_mask !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got op0 lane0 %h mask %h expected 0", lane(rsp_op0, 0), rsp_mask); end
    rd_req_valid = 1'b0; wb_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_write_read();
    wb_valid = 1'b1; wb_warp = 4'd3; wb_rd = 4'd5; wb_mask = 16'hFFFF;
    for (int i = 0; i < L; i++) wb_data[i*DW +: DW] = 32'(i) * 32'h1111_1111;
    #1;
    n_checks++; if (wb_ready !== 1'b1 || rf_write_en !== 16'hFFFF || rf_warp_selector !== 4'd3) begin n_fail++; $display("FAIL wr_grant: got ready %b en %h sel %0d expected 1 FFFF 3", wb_ready, rf_write_en, rf_warp_selector); end
    @(negedge clk);
    wb_valid = 1'b0;
    rd_req_valid = 1'b1; rd_req_warp = 4'd3; rd_req_rs0 = 4'd5; rd_req_rs1 = 4'd5; rd_req_mask = 16'hFFFF; rsp_ready = 1'b1;
    #1;
    n_checks++; if (rd_req_ready !== 1'b1 || rf_read_en_0 !== 16'hFFFF) begin n_fail++; $display("FAIL rd_grant: got ready %b en %h expected 1 FFFF", rd_req_ready, rf_read_en_0); end
    @(negedge clk);
    rd_req_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_valid: got %b expected 1", rsp_valid); end
    n_checks++; if (lane(rsp_op0, 7) !== 32'h7777_7777 || lane(rsp_op1, 7) !== 32'h7777_7777) begin n_fail++; $display("FAIL wr_rd_lane7: got %h %h expected 77777777", lane(rsp_op0, 7), lane(rsp_op1, 7)); end
    n_checks++; if (lane(rsp_op0, 15) !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wr_rd_lane15: got %h expected ffffffff", lane(rsp_op0, 15)); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_forward();
    wb_valid = 1'b1; wb_warp = 4'd2; wb_rd = 4'd4; wb_mask = 16'h00FF;
    for (int i = 0; i < L; i++) wb_data[i*DW +: DW] = 32'hA5A5_A5A5;
    rd_req_valid = 1'b1; rd_req_warp = 4'd2; rd_req_rs0 = 4'd4; rd_req_rs1 = 4'd6; rd_req_mask = 16'hFFFF;
    #1;
    n_checks++; if (wb_ready !== 1'b1 || rd_req_ready !== 1'b1 || rf_warp_selector !== 4'd2) begin n_fail++; $display("FAIL fwd_grant: got wr %b rd %b sel %0d expected 1 1 2", wb_ready, rd_req_ready, rf_warp_selector); end
    @(negedge clk);
    wb_valid = 1'b0; rd_req_valid = 1'b0;
    n_checks++; if (lane(rsp_op0, 0) !== 32'hA5A5_A5A5 || lane(rsp_op0, 7) !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL fwd_low: got %h %h expected a5a5a5a5", lane(rsp_op0, 0), lane(rsp_op0, 7)); end
    n_checks++; if (lane(rsp_op0, 8) !== 32'h1002_0408 || lane(rsp_op0, 15) !== 32'h1002_040F) begin n_fail++; $display("FAIL fwd_high: got %h %h expected 10020408 1002040f", lane(rsp_op0, 8), lane(rsp_op0, 15)); end
    n_checks++; if (lane(rsp_op1, 0) !== 32'h1002_0600 || lane(rsp_op1, 12) !== 32'h1002_060C) begin n_fail++; $display("FAIL fwd_op1: got %h %h expected 10020600 1002060c", lane(rsp_op1, 0), lane(rsp_op1, 12)); end
  endtask

  task automatic test_starve();
    wb_valid = 1'b1; wb_warp = 4'd1; wb_rd = 4'd0; wb_mask = 16'h0001;
    rd_req_valid = 1'b1; rd_req_warp = 4'd9; rd_req_rs0 = 4'd1; rd_req_rs1 = 4'd2; rd_req_mask = 16'hFFFF; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (wb_ready !== (k < 3) || rd_req_ready !== (k == 3)) begin n_fail++; $display("FAIL starve_grant%0d: got wr %b rd %b expected %b %b", k, wb_ready, rd_req_ready, k < 3, k == 3); end
      n_checks++; if (dut.u_arb.starve_cnt !== 2'(k)) begin n_fail++; $display("FAIL starve_cnt%0d: got %0d expected %0d", k, dut.u_arb.starve_cnt, k); end
      @(negedge clk);
    end
    wb_valid = 1'b0; rd_req_valid = 1'b0; rsp_ready = 1'b0;
    n_checks++; if (dut.u_arb.starve_cnt !== 2'd0) begin n_fail++; $display("FAIL starve_clear: got %0d expected 0", dut.u_arb.starve_cnt); end
    n_checks++; if (rsp_valid !== 1'b1 || lane(rsp_op0, 5) !== 32'h1009_0105) begin n_fail++; $display("FAIL starve_rsp: got %b %h expected 1 10090105", rsp_valid, lane(rsp_op0, 5)); end
  endtask

  task automatic test_stall();
    rd_req_valid = 1'b1; rd_req_warp = 4'd9; rd_req_rs0 = 4'd3; rd_req_rs1 = 4'd4; rd_req_mask = 16'hFFFF; rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (rd_req_ready !== 1'b0 || rf_read_en_0 !== 16'h0) begin n_fail++; $display("FAIL stall_ready%0d: got %b en %h expected 0 0000", k, rd_req_ready, rf_read_en_0); end
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1 || lane(rsp_op0, 5) !== 32'h1009_0105 || lane(rsp_op1, 5) !== 32'h1009_0205) begin n_fail++; $display("FAIL stall_hold%0d: got %b %h %h expected 1 10090105 10090205", k, rsp_valid, lane(rsp_op0, 5), lane(rsp_op1, 5)); end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b expected 1", rd_req_ready); end
    @(negedge clk);
    rd_req_valid = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || lane(rsp_op0, 5) !== 32'h1009_0305) begin n_fail++; $display("FAIL stall_new: got %b %h expected 1 10090305", rsp_valid, lane(rsp_op0, 5)); end
  endtask

  task automatic test_mask();
    rd_req_valid = 1'b1; rd_req_warp = 4'd6; rd_req_rs0 = 4'd7; rd_req_rs1 = 4'd8; rd_req_mask = 16'h8001; rsp_ready = 1'b1;
    #1;
    n_checks++; if (rf_read_en_0 !== 16'h8001 || rf_read_en_1 !== 16'h8001) begin n_fail++; $display("FAIL mask_en: got %h %h expected 8001", rf_read_en_0, rf_read_en_1); end
    @(negedge clk);
    rd_req_valid = 1'b0;
    n_checks++; if (lane(rsp_op0, 0) !== 32'h1006_0700 || lane(rsp_op0, 15) !== 32'h1006_070F || lane(rsp_op1, 15) !== 32'h1006_080F) begin n_fail++; $display("FAIL mask_on: got %h %h %h expected 10060700 1006070f 1006080f", lane(rsp_op0, 0), lane(rsp_op0, 15), lane(rsp_op1, 15)); end
    n_checks++; if (lane(rsp_op0, 1) !== 32'h0 || lane(rsp_op1, 7) !== 32'h0 || lane(rsp_op0, 14) !== 32'h0) begin n_fail++; $display("FAIL mask_off: got %h %h %h expected 0", lane(rsp_op0, 1), lane(rsp_op1, 7), lane(rsp_op0, 14)); end
    n_checks++; if (rsp_mask !== 16'h8001) begin n_fail++; $display("FAIL mask_copy: got %h expected 8001", rsp_mask); end
  endtask

  task automatic test_back_to_back();
    rd_req_valid = 1'b1; rd_req_warp = 4'd4; rd_req_mask = 16'hFFFF; rsp_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      rd_req_rs0 = 4'(k); rd_req_rs1 = 4'(k + 8);
      #1;
      n_checks++; if (rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", k, rd_req_ready); end
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1 || lane(rsp_op0, 2) !== pat(4, k, 2) || lane(rsp_op1, 2) !== pat(4, k + 8, 2)) begin n_fail++; $display("FAIL b2b_data%0d: got %b %h %h expected 1 %h %h", k, rsp_valid, lane(rsp_op0, 2), lane(rsp_op1, 2), pat(4, k, 2), pat(4, k + 8, 2)); end
    end
    rd_req_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    rsp_ready = 1'b0;
    rst = 1'b1;
    rd_req_valid = 1'b1; rd_req_warp = 4'd5; rd_req_mask = 16'hFFFF;
    wb_valid = 1'b1; wb_warp = 4'd5; wb_mask = 16'hFFFF;
    #1;
    n_checks++; if (rf_write_en !== 16'h0 || rf_read_en_0 !== 16'h0 || rf_read_en_1 !== 16'h0 || wb_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_en: got %h %h %h %b expected all 0", rf_write_en, rf_read_en_0, rf_read_en_1, wb_ready); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || rsp_op0 !== '0 || rsp_mask !== '0) begin n_fail++; $display("FAIL midrst_rsp: got %b %h %h expected 0", rsp_valid, lane(rsp_op0, 0), rsp_mask); end
    rd_req_valid = 1'b0; wb_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got %b expected 0", rsp_valid); end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_write_read();
    test_forward();
    test_starve();
    test_stall();
    test_mask();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
